// File: rtl/hexload_pkg.sv
// Shared constants for the ASCII hex instruction loader: framing characters,
// loader FSM states and error bit positions.
package hexload_pkg;

   localparam logic [7:0] ASCII_LF     = 8'h0A;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_DOLLAR = 8'h24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int ERR_MALFORMED = 0;
   localparam int ERR_FULL      = 1;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational classifier for one received byte: hex digit (with value),
// line terminator, end-of-load marker, or ignorable.
module hex_ascii_decode
   import hexload_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic       o_is_hex,
   output logic       o_is_term,
   output logic       o_is_end,
   output logic [3:0] o_nibble
);

   // Letters A-F / a-f share low nibbles 1..6, so +9 yields 10..15
   always_comb begin
      o_is_hex  = 1'b0;
      o_is_term = 1'b0;
      o_is_end  = 1'b0;
      o_nibble  = i_byte[3:0];
      if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
         o_is_hex = 1'b1;
      end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                   (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
         o_is_hex = 1'b1;
         o_nibble = i_byte[3:0] + 4'd9;
      end else if (i_byte == ASCII_LF || i_byte == ASCII_CR) begin
         o_is_term = 1'b1;
      end else if (i_byte == ASCII_DOLLAR) begin
         o_is_end = 1'b1;
      end
   end

endmodule

// File: rtl/hex_instr_loader.sv
// Line-based ASCII hex loader feeding the instruction memory write port.
// Optional build macro HEXLOAD_ECHO_EN: echoes every consumed byte to the
// transmitter and stalls consumption while the transmitter is busy.
module hex_instr_loader
   import hexload_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdy,
   output logic              rx_rdy_clr,
   input  logic              cpu_run,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic [7:0]        echo_data,
   output logic              echo_wr,
   input  logic              echo_busy,
   output logic [ADDR_W:0]   word_cnt,
   output logic              load_done,
   output logic [1:0]        err
);

   localparam int HEX_DIGITS = DATA_W / 4;
   localparam int CNT_W      = $clog2(HEX_DIGITS + 1);
   localparam int WCNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(HEX_DIGITS);
   localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(2 ** ADDR_W);

   state_t              r_state, w_next;
   logic [DATA_W-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_skip;          // overlong word: drop digits until terminator
   logic                r_rx_rdy_clr;
   logic                r_imem_we;
   logic [ADDR_W-1:0]   r_imem_addr;
   logic [DATA_W-1:0]   r_imem_wdata;
   logic [WCNT_W-1:0]   r_word_cnt;
   logic                r_load_done;
   logic [1:0]          r_err;
   logic                w_is_hex, w_is_term, w_is_end;
   logic [3:0]          w_nibble;
   logic                w_echo_ok, w_consume, w_valid_term;

   hex_ascii_decode u_decode (
      .i_byte    (rx_data),
      .o_is_hex  (w_is_hex),
      .o_is_term (w_is_term),
      .o_is_end  (w_is_end),
      .o_nibble  (w_nibble)
   );

`ifdef HEXLOAD_ECHO_EN
   logic       r_echo_wr;
   logic [7:0] r_echo_data;

   assign w_echo_ok = !echo_busy;

   // Echo copy of each consumed byte, aligned with rx_rdy_clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_echo_wr   <= 1'b0;
         r_echo_data <= 8'h00;
      end else begin
         r_echo_wr <= w_consume;
         if (w_consume) r_echo_data <= rx_data;
      end
   end

   assign echo_wr   = r_echo_wr;
   assign echo_data = r_echo_data;
`else
   logic w_unused_echo_busy;
   assign w_unused_echo_busy = echo_busy;
   assign w_echo_ok = 1'b1;
   assign echo_wr   = 1'b0;
   assign echo_data = 8'h00;
`endif

   assign w_consume    = rx_rdy && !cpu_run && !r_load_done && (r_state == IDLE) && w_echo_ok;
   assign w_valid_term = w_is_term && !r_skip && (r_cnt == CNT_FULL);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state: every consume passes through GAP to mask the stale rx_rdy
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_consume) w_next = w_valid_term ? WRITE : GAP;
         WRITE:   w_next = GAP;
         GAP:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Byte parsing, memory write and sticky status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_skip       <= 1'b0;
         r_rx_rdy_clr <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_word_cnt   <= '0;
         r_load_done  <= 1'b0;
         r_err        <= 2'b00;
      end else begin
         r_rx_rdy_clr <= w_consume;
         r_imem_we    <= 1'b0;
         if (w_consume) begin
            if (w_is_end) begin
               r_load_done <= 1'b1;
               r_cnt       <= '0;
               r_skip      <= 1'b0;
            end else if (w_is_term) begin
               if (!r_skip && r_cnt != '0 && r_cnt != CNT_FULL) r_err[ERR_MALFORMED] <= 1'b1;
               r_cnt  <= '0;
               r_skip <= 1'b0;
            end else if (w_is_hex && !r_skip) begin
               if (r_cnt == CNT_FULL) begin
                  r_err[ERR_MALFORMED] <= 1'b1;
                  r_skip               <= 1'b1;
               end else begin
                  r_acc <= {r_acc[DATA_W-5:0], w_nibble};
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
         end
         // Accumulator is stable in WRITE since nothing is consumed there
         if (r_state == WRITE) begin
            if (r_word_cnt == WCNT_FULL) begin
               r_err[ERR_FULL] <= 1'b1;
            end else begin
               r_imem_we    <= 1'b1;
               r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
               r_imem_wdata <= r_acc;
            end
         end
         if (r_imem_we) r_word_cnt <= r_word_cnt + WCNT_W'(1);
      end
   end

   assign rx_rdy_clr = r_rx_rdy_clr;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign word_cnt   = r_word_cnt;
   assign load_done  = r_load_done;
   assign err        = r_err;

endmodule

// File: doc/hex_instr_loader.md
# hex_instr_loader

Upstream feeder for the CPU instruction memory. Consumes received bytes from the UART receiver over its `rdy`/`rdy_clr` handshake and parses ASCII hex text into 32-bit words. Writes the words sequentially into the instruction memory write port and reports load completion and errors. Sits between the `uart` receiver and `instr_mem`. Framing is line-based, replacing raw nibble counting.

## Interface
- `ADDR_W`, 4: instruction memory address width; depth = 2^ADDR_W words
- `DATA_W`, 32: word width; hex digits per word = DATA_W/4
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `rx_data` in 8: received byte from UART
- `rx_rdy` in 1: byte valid, level, held until cleared
- `rx_rdy_clr` out 1: one-cycle pulse acknowledging a consumed byte
- `cpu_run` in 1: CPU running; loader consumes no bytes while high
- `imem_we` out 1: one-cycle write strobe
- `imem_addr` out ADDR_W: write address
- `imem_wdata` out DATA_W: write data
- `echo_data` out 8: byte to retransmit
- `echo_wr` out 1: one-cycle transmit request
- `echo_busy` in 1: transmitter busy
- `word_cnt` out ADDR_W+1: words written since reset
- `load_done` out 1: sticky, set by end-of-load character
- `err` out 2: sticky; bit0 = malformed word, bit1 = memory full

## Operation
- Consume condition: `rx_rdy && !cpu_run && !load_done && state==IDLE` (and `!echo_busy` under echo). On consume, `rx_rdy_clr` pulses and the byte is classified.
- Classes:
  - hex digits 0x30–0x39, 0x41–0x46, 0x61–0x66 (case-insensitive) → nibble
  - 0x0A or 0x0D → terminator
  - 0x24 '$' → end-of-load
  - space, tab and all other bytes → ignored (consumed, no state change)
- Nibble: shifted into accumulator MSB-first (first digit → [DATA_W-1:DATA_W-4]); digit count increments. A digit when the count is already DATA_W/4 sets err[0], discards the word, and ignores digits until the next terminator.
- Terminator:
  - count == DATA_W/4 → write word.
  - count == 0 → ignored, so CR LF pairs and blank lines are harmless.
  - 0 < count < DATA_W/4 → err[0], word discarded.
  - The count is cleared in every case.
- Write: `imem_addr` = `word_cnt[ADDR_W-1:0]`, then `word_cnt` increments. If `word_cnt` == 2^ADDR_W, no write occurs, err[1] is set, and the count stays saturated (no wrap).
- End-of-load: `load_done` is set and a partial word is discarded silently. All later bytes are left unconsumed until `rst`.
- FSM states:
  - IDLE → GAP on every consume.
  - IDLE → WRITE on a valid terminator.
  - WRITE → GAP.
  - GAP → IDLE.
- GAP is one cycle. It masks `rx_rdy` that is still high in the cycle after `rx_rdy_clr`.

## Timing
- Reset values: all outputs 0; accumulator, count and FSM (IDLE) cleared.
- Reset mid-word or mid-write aborts it with no write strobe.
- Consume-to-`rx_rdy_clr`: registered, asserted the cycle after the consume condition is sampled.
- `imem_we` is asserted exactly one cycle after `rx_rdy_clr` of the terminator. `imem_addr` and `imem_wdata` are valid in the same cycle.
- `word_cnt` updates the cycle after `imem_we`.
- Maximum throughput: one byte per 2 cycles, or 3 for a terminating byte.
- `cpu_run` rising while a word is partial: the partial word is held, and parsing resumes when `cpu_run` falls.
- `err` bits and `load_done` persist until `rst`.

## Configuration
- `HEXLOAD_ECHO_EN` defined:
  - every consumed byte is copied to `echo_data` with `echo_wr` pulsed in the same cycle as `rx_rdy_clr`
  - consumption additionally waits for `!echo_busy`
- Undefined:
  - `echo_wr`=0 and `echo_data`=0 constantly
  - `echo_busy` is ignored

## Structure
- Package `hexload_pkg`: ASCII constants (LF, CR, DOLLAR), FSM state enum, err bit indices.
- Sub-module `hex_ascii_decode`: combinational; input byte → `{is_hex, is_term, is_end, nibble[3:0]}`.
- FSM, accumulator and counters live in `hex_instr_loader`.

## Test plan
- Send "00500093\n" → one `imem_we`, addr 0, data 0x00500093; `word_cnt`=1; `err`=0.
- Send "deadBEEF\r\n12345678\n" → addr 0 = 0xDEADBEEF, addr 1 = 0x12345678; CR-LF yields no extra write.
- Send "1234\n" then "123456789\n" → no writes, err[0]=1, `word_cnt`=0.
- Send 17 valid lines → 16 writes (addr 0–15), the 17th is rejected, err[1]=1, `word_cnt`=16.
- Send "0000" then "$" then "11111111\n" → `load_done`=1, no writes, trailing bytes leave `rx_rdy` unacknowledged.
- Hold `rx_rdy` high with `cpu_run`=1 → no `rx_rdy_clr`; assert `rst` mid-word → all outputs 0 next cycle.
